// File: rtl/uart_packet_transmitter.sv
// Buffered UART transmitter: queues words in a small FIFO, serialises them as
// start/data/[parity]/stop frames and keeps a running CRC-8 that can be sent
// as a trailing frame.
//
// Handshake: a word is taken on a rising clock edge when send_i && ready_o.
// A CRC trailer is taken when finish_i && ready_o && !send_i. When ready_o is
// low, both requests are ignored and nothing is queued.
`timescale 1ns/1ps
module uart_packet_transmitter #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter logic [7:0]  CRC_POLY     = 8'h07
) (
  input  logic                          clock_i,
  input  logic                          reset_ni,
  input  logic [DATA_BITS-1:0]          data_in_i,
  input  logic                          send_i,
  input  logic                          finish_i,
  input  logic                          clear_crc_i,
  input  logic                          hold_i,
  output logic                          data_out_o,
  output logic                          ready_o,
  output logic                          acknowledge_o,
  output logic                          busy_o,
  output logic [7:0]                    crc8_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [2:0]                    state_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned KW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  // FIFO entry: {crc_flag, byte}; data words are zero-extended to 8 bits.
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    crc_q, crc_d;
  logic          full, pop, push, push_data, push_fin;
  logic [8:0]    push_entry;

  state_e        state_q, state_d;
  logic [KW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    frame_q, frame_d;
  logic          flag_q, flag_d;
  logic          line_q, line_d;
  logic          ack_q, ack_d;
  logic          bit_done;

  // One CRC-8 step over a whole byte, MSB first, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  // FIFO control and CRC accumulator next-state; a pop frees a slot in the same cycle.
  always_comb begin
    full       = (count_q == CW'(FIFO_DEPTH));
    pop        = (state_q == IDLE) && (count_q != '0) && !hold_i;
    ready_o    = !full || pop;
    push_data  = send_i && ready_o;
    push_fin   = finish_i && ready_o && !send_i;
    push       = push_data || push_fin;
    push_entry = push_data ? {1'b0, 8'(data_in_i)} : {1'b1, crc_q};
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    crc_d      = crc_q;
    if (push_fin) begin
      crc_d = '0;
    end else if (push_data) begin
      crc_d = crc8_step(clear_crc_i ? 8'h00 : crc_q, 8'(data_in_i));
    end else if (clear_crc_i) begin
      crc_d = '0;
    end
  end

  // FIFO storage; contents are only read while count_q says they are valid.
  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  // FIFO pointers, occupancy and CRC registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      crc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      crc_q    <= crc_d;
    end
  end

  // Frame sequencer: bit timing, state transitions and the line level for this state.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    flag_d    = flag_q;
    line_d    = 1'b1;
    ack_d     = 1'b0;
    bit_done  = (clk_cnt_q == KW'(CLKS_PER_BIT - 1));
    if (state_q != IDLE) begin
      clk_cnt_d = bit_done ? '0 : clk_cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d   = START;
          frame_d   = mem_q[rd_ptr_q][7:0];
          flag_d    = mem_q[rd_ptr_q][8];
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        line_d = 1'b0;
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        line_d = frame_q[bit_cnt_q];
        if (bit_done) begin
          if (bit_cnt_q == (flag_q ? 3'd7 : 3'(DATA_BITS - 1))) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PAR: begin
        // Unused upper bits are zero, so parity over all 8 equals parity over the bits sent.
        line_d = (PARITY == 2) ? ~^frame_q : ^frame_q;
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        line_d = 1'b1;
        if (bit_done) begin
          if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
            ack_d     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state plus registered line and acknowledge, kept aligned with each other.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      flag_q    <= 1'b0;
      line_q    <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      flag_q    <= flag_d;
      line_q    <= line_d;
      ack_q     <= ack_d;
    end
  end

  assign data_out_o    = line_q;
  assign acknowledge_o = ack_q;
  assign busy_o        = (state_q != IDLE) || (count_q != '0) || ack_q;
  assign crc8_o        = crc_q;
  assign fifo_count_o  = count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_uart_packet_transmitter.sv
// Bench for uart_packet_transmitter: three instances (no parity / even parity
// with two stop bits / odd parity) share one stimulus stream. A frame-level
// model decodes every frame on each line and compares it cycle by cycle.
`timescale 1ns/1ps
module tb_uart_packet_transmitter;
  localparam int DB  = 8;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam int TO  = 5000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DB-1:0] data_in = '0;
  logic send_i = 0, finish_i = 0, clear_i = 0, hold_i = 0;
  logic dout [3];
  logic ack  [3];
  logic rdy  [3];
  logic busy [3];
  logic [7:0] crc [3];
  logic [2:0] cnt [3];
  logic [2:0] st  [3];

  int checks = 0, errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] msg[$];
  int rd_idx [3];
  int done_cnt [3];
  int ack_cnt [3];
  int n_starts [3];
  int starts [3][128];

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0h expected=%0h", name, g, act, expv);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // CRC-8 as remainder of the zero-augmented message divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_of(input logic [7:0] m[$]);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < m.size(); i++) begin
      for (int b = 7; b >= 0; b--) begin
        r = {r[7:0], m[i][b]};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    for (int b = 0; b < 8; b++) begin
      r = {r[7:0], 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  function automatic int frame_clks(input int g);
    return (1 + DB + ((g == 0) ? 0 : 1) + ((g == 1) ? 2 : 1)) * CPB;
  endfunction

  function automatic bit all_rdy();
    return rdy[0] && rdy[1] && rdy[2];
  endfunction

  function automatic bit all_idle();
    for (int g = 0; g < 3; g++) begin
      if (busy[g] || !dout[g] || rd_idx[g] != exp_q.size()) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) if (ack[g] === 1'b1) ack_cnt[g] <= ack_cnt[g] + 1;
  end

  generate
    for (genvar g = 0; g < 3; g++) begin : gen_inst
      localparam int P = (g == 0) ? 0 : ((g == 1) ? 1 : 2);
      localparam int S = (g == 1) ? 2 : 1;

      uart_packet_transmitter #(
        .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
        .PARITY(P), .STOP_BITS(S), .CRC_POLY(8'h07)
      ) dut (
        .clock_i(clk), .reset_ni(rst_n), .data_in_i(data_in),
        .send_i(send_i), .finish_i(finish_i), .clear_crc_i(clear_i), .hold_i(hold_i),
        .data_out_o(dout[g]), .ready_o(rdy[g]), .acknowledge_o(ack[g]), .busy_o(busy[g]),
        .crc8_o(crc[g]), .fifo_count_o(cnt[g]), .state_o(st[g])
      );

      // monitor: expected frame level sequence built from the queued entry
      initial begin : mon
        logic [8:0] e;
        logic lv[$];
        int nb, ones, total;
        bit aborted;
        forever begin
          @(negedge clk);
          if (!rst_n || dout[g]) continue;
          if (n_starts[g] < 128) starts[g][n_starts[g]] = cyc;
          n_starts[g]++;
          if (rd_idx[g] >= exp_q.size()) begin
            check("unexpected_frame", g, rd_idx[g], exp_q.size());
            continue;
          end
          e = exp_q[rd_idx[g]];
          rd_idx[g]++;
          nb = e[8] ? 8 : DB;
          lv.delete();
          lv.push_back(1'b0);
          ones = 0;
          for (int i = 0; i < nb; i++) begin
            lv.push_back(e[i]);
            ones += int'(e[i]);
          end
          if (P == 1) lv.push_back((ones % 2) == 1);
          if (P == 2) lv.push_back((ones % 2) == 0);
          for (int i = 0; i < S; i++) lv.push_back(1'b1);
          total = lv.size() * CPB;
          aborted = 0;
          for (int k = 0; k < total; k++) begin
            if (k > 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1;
              break;
            end
            check("line", g, dout[g], lv[k / CPB]);
            check("ack", g, ack[g], (k == total - 1));
          end
          if (!aborted) begin
            done_cnt[g]++;
            @(negedge clk);
            if (rst_n) check("gap", g, dout[g], 1);
          end
        end
      end
    end
  endgenerate

  // driver: one request, waits for all instances to be ready
  task automatic drive(input logic s, input logic f, input logic c, input logic [7:0] w);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((s || f) && !all_rdy() && guard < TO) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= TO) fail_to("ready_wait");
    send_i = s; finish_i = f; clear_i = c; data_in = w;
    if (s) begin
      if (c) msg.delete();
      msg.push_back(w);
      exp_q.push_back({1'b0, w});
    end else if (f) begin
      exp_q.push_back({1'b1, crc_of(msg)});
      msg.delete();
    end else if (c) begin
      msg.delete();
    end
    @(posedge clk);
    #1;
    send_i = 0; finish_i = 0; clear_i = 0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) check("crc", g, crc[g], crc_of(msg));
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!all_idle() && guard < TO) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= TO) fail_to("idle_wait");
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) check("drained", g, rd_idx[g], exp_q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int mc, r, gap;
    int a0 [3];
    int n0 [3];
    logic exp_ready;
    for (int g = 0; g < 3; g++) begin
      rd_idx[g] = 0; done_cnt[g] = 0; ack_cnt[g] = 0; n_starts[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_dout", g, dout[g], 1);
      check("rst_ready", g, rdy[g], 1);
      check("rst_ack", g, ack[g], 0);
      check("rst_busy", g, busy[g], 0);
      check("rst_crc", g, crc[g], 0);
      check("rst_count", g, cnt[g], 0);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);

    // single frame and start-bit latency
    drive(1, 0, 0, 8'h55);
    @(negedge clk);
    for (int g = 0; g < 3; g++) check("latency_idle", g, dout[g], 1);
    @(negedge clk);
    for (int g = 0; g < 3; g++) check("latency_start", g, dout[g], 0);
    wait_idle();

    // parity cases
    drive(1, 0, 0, 8'h07);
    wait_idle();

    // CRC over "123456789" and trailer frame
    drive(0, 0, 1, 8'h00);
    for (int i = 0; i < 9; i++) drive(1, 0, 0, 8'h31 + 8'(i));
    for (int g = 0; g < 3; g++) check("crc_check_value", g, crc[g], 8'hF4);
    drive(0, 1, 0, 8'h00);
    check("trailer_entry", 0, exp_q[exp_q.size() - 1], {1'b1, 8'hF4});
    wait_idle();

    // send and finish together: only the word is taken
    drive(0, 0, 1, 8'h00);
    drive(1, 1, 0, 8'h01);
    for (int g = 0; g < 3; g++) check("crc_send_wins", g, crc[g], 8'h07);
    wait_idle();

    // hold with an overfilled FIFO
    @(negedge clk);
    hold_i = 1;
    mc = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      exp_ready = (mc < DEPTH);
      for (int g = 0; g < 3; g++) check("ready_hold", g, rdy[g], exp_ready);
      send_i = 1;
      data_in = 8'hC0 + 8'(i);
      if (exp_ready) begin
        mc++;
        msg.push_back(data_in);
        exp_q.push_back({1'b0, data_in});
      end
      @(posedge clk);
      #1;
    end
    send_i = 0;
    repeat (10) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("held_count", g, cnt[g], DEPTH);
      check("held_ready", g, rdy[g], 0);
      check("held_dout", g, dout[g], 1);
      check("held_busy", g, busy[g], 1);
      check("held_crc", g, crc[g], crc_of(msg));
      a0[g] = ack_cnt[g];
      n0[g] = n_starts[g];
    end
    hold_i = 0;
    wait_idle();
    for (int g = 0; g < 3; g++) begin
      check("release_acks", g, ack_cnt[g] - a0[g], 4);
      check("release_frames", g, n_starts[g] - n0[g], 4);
      check("release_busy", g, busy[g], 0);
      for (int j = 1; j < 4; j++) begin
        if (n0[g] + j < 128)
          check("b2b_spacing", g, starts[g][n0[g] + j] - starts[g][n0[g] + j - 1], frame_clks(g) + 1);
      end
    end

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 15);
      gap = $urandom_range(0, 12);
      hold_i = ($urandom_range(0, 3) == 0);
      repeat (gap) @(negedge clk);
      hold_i = 0;
      if (r < 11)      drive(1, 0, ($urandom_range(0, 7) == 0), 8'($urandom));
      else if (r < 13) drive(0, 1, 0, 8'h00);
      else if (r < 14) drive(1, 1, 0, 8'($urandom));
      else             drive(0, 0, 1, 8'h00);
    end
    wait_idle();

    // reset in the middle of a frame
    drive(1, 0, 0, 8'hA5);
    drive(1, 0, 0, 8'h5A);
    repeat (10) @(negedge clk);
    for (int g = 0; g < 3; g++) a0[g] = ack_cnt[g];
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check("midrst_dout", g, dout[g], 1);
      check("midrst_count", g, cnt[g], 0);
      check("midrst_crc", g, crc[g], 0);
      check("midrst_ready", g, rdy[g], 1);
    end
    repeat (3) @(negedge clk);
    exp_q.delete();
    msg.delete();
    for (int g = 0; g < 3; g++) rd_idx[g] = 0;
    rst_n = 1;
    repeat (60) @(negedge clk);
    for (int g = 0; g < 3; g++) check("midrst_no_ack", g, ack_cnt[g], a0[g]);
    drive(1, 0, 0, 8'h3C);
    wait_idle();

    for (int g = 0; g < 3; g++) check("ack_total", g, ack_cnt[g], done_cnt[g]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
